i2c_master_seq: RTL and testbench

Parametrised, bit-accurate I2C master that executes complete single-address transactions of 0 to 2^LEN_W-1 data bytes, in either write or read direction. It generates SCL from the system clock through a programmable divider, drives SDA open-drain, checks slave ACKs, and ACK/NACKs read bytes. It streams payload through valid/ready byte ports. It replaces the fixed single-byte master as the I2C engine of the peripheral subsystem.

---
 rtl/i2c_master_seq.sv | 221 ++++++++++++++++++++++
 tb/tb_i2c_master_seq.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_seq.sv
// I2C master: one START, address byte, 0..2^LEN_W-1 data bytes (write or read), STOP.
// SCL is generated from clk in quarter-bit phases; SDA is open-drain.
module i2c_master_seq #(
    parameter int CLK_DIV = 250,
    parameter int LEN_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [6:0]       addr,
    input  logic             rw,
    input  logic [LEN_W-1:0] len,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             scl,
    inout  wire              sda,
    output logic             busy,
    output logic             done,
    output logic             nack_err,
    output logic [3:0]       dbg_state
);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WRITE,
        S_WRITE_ACK, S_READ, S_READ_ACK, S_STOP
    } state_t;

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       ph_q, ph_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             rw_q, rw_d;
    logic             nack_q, nack_d;
    logic             samp_q, samp_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             done_q, done_d;
    logic             scl_q, scl_d;
    logic             sda_oe_q, sda_oe_d;
    logic [1:0]       sda_sync_q;

    logic sda_s, tick, bit_end, samp_pt, at_take, stall;

    // Line levels as a function of (next) state so scl/sda come straight from flops.
    function automatic logic [1:0] line_drive(input state_t st, input logic [1:0] ph,
                                              input logic bit_out, input logic ack_out);
        logic s, oe;
        s  = 1'b1;
        oe = 1'b0;
        case (st)
            S_START:                           begin s = (ph != 2'd3); oe = ph[1]; end
            S_ADDR, S_WRITE:                   begin s = ph[0] ^ ph[1]; oe = ~bit_out; end
            S_ADDR_ACK, S_WRITE_ACK, S_READ:   begin s = ph[0] ^ ph[1]; oe = 1'b0; end
            S_READ_ACK:                        begin s = ph[0] ^ ph[1]; oe = ack_out; end
            S_STOP:                            begin s = (ph != 2'd0); oe = ~ph[1]; end
            default:                           begin s = 1'b1; oe = 1'b0; end
        endcase
        return {s, oe};
    endfunction

    assign sda_s   = sda_sync_q[1];
    assign tick    = (cnt_q == CNT_MAX);
    assign bit_end = tick && (ph_q == 2'd3);
    assign samp_pt = tick && (ph_q == 2'd2);
    assign at_take = (state_q == S_WRITE) && (bit_q == 3'd7) && (ph_q == 2'd0) && (cnt_q == '0);
    assign stall   = at_take && !tx_valid;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ph_d       = ph_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        rem_d      = rem_q;
        rw_d       = rw_q;
        nack_d     = nack_q;
        samp_d     = samp_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        done_d     = 1'b0;
        tx_ready   = 1'b0;

        if (state_q != S_IDLE && !stall) begin
            cnt_d = tick ? '0 : cnt_q + CW'(1);
            if (tick) ph_d = ph_q + 2'd1;
        end
        if (samp_pt) samp_d = sda_s;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_START;
                    shift_d = {addr, rw};
                    rw_d    = rw;
                    rem_d   = len;
                    nack_d  = 1'b0;
                    cnt_d   = '0;
                    ph_d    = 2'd0;
                    bit_d   = 3'd7;
                end
            end
            S_START: if (bit_end) state_d = S_ADDR;
            // bit_q wraps 0 -> 7, leaving it ready for the next byte.
            S_ADDR: begin
                if (bit_end) begin
                    shift_d = {shift_q[6:0], 1'b0};
                    bit_d   = bit_q - 3'd1;
                    if (bit_q == 3'd0) state_d = S_ADDR_ACK;
                end
            end
            S_ADDR_ACK: begin
                if (bit_end) begin
                    if (samp_q) begin
                        nack_d  = 1'b1;
                        state_d = S_STOP;
                    end else if (rem_q == '0) state_d = S_STOP;
                    else if (rw_q)            state_d = S_READ;
                    else                      state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (at_take && tx_valid) begin
                    tx_ready = 1'b1;
                    shift_d  = tx_data;
                end
                if (bit_end) begin
                    shift_d = {shift_q[6:0], 1'b0};
                    bit_d   = bit_q - 3'd1;
                    if (bit_q == 3'd0) state_d = S_WRITE_ACK;
                end
            end
            S_WRITE_ACK: begin
                if (bit_end) begin
                    if (samp_q) begin
                        nack_d  = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        rem_d   = rem_q - LEN_W'(1);
                        state_d = (rem_q == LEN_W'(1)) ? S_STOP : S_WRITE;
                    end
                end
            end
            S_READ: begin
                if (samp_pt) shift_d = {shift_q[6:0], sda_s};
                if (bit_end) begin
                    bit_d = bit_q - 3'd1;
                    if (bit_q == 3'd0) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                        rem_d      = rem_q - LEN_W'(1);
                        state_d    = S_READ_ACK;
                    end
                end
            end
            S_READ_ACK: if (bit_end) state_d = (rem_q == '0) ? S_STOP : S_READ;
            S_STOP: begin
                if (bit_end) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        {scl_d, sda_oe_d} = line_drive(state_d, ph_d, shift_d[7], rem_d != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            ph_q       <= 2'd0;
            bit_q      <= 3'd7;
            shift_q    <= 8'h00;
            rem_q      <= '0;
            rw_q       <= 1'b0;
            nack_q     <= 1'b0;
            samp_q     <= 1'b1;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            done_q     <= 1'b0;
            scl_q      <= 1'b1;
            sda_oe_q   <= 1'b0;
            sda_sync_q <= 2'b11;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ph_q       <= ph_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            rem_q      <= rem_d;
            rw_q       <= rw_d;
            nack_q     <= nack_d;
            samp_q     <= samp_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            done_q     <= done_d;
            scl_q      <= scl_d;
            sda_oe_q   <= sda_oe_d;
            sda_sync_q <= {sda_sync_q[0], sda};
        end
    end

    assign sda       = sda_oe_q ? 1'b0 : 1'bz;
    assign scl       = scl_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign nack_err  = nack_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_i2c_master_seq.sv
// Directed bench for i2c_master_seq with a bit-indexed I2C slave responder.
module tb_i2c_master_seq;
    localparam int CLK_DIV = 4;
    localparam int LEN_W   = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [6:0] addr = '0;
    logic       rw = 1'b0;
    logic [7:0] len = '0;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready, rx_valid, scl, busy, done, nack_err;
    logic [7:0] rx_data;
    logic [3:0] dbg_state;
    wire        sda;
    logic       slave_drv = 1'b0;
    logic       sda_line;

    pullup (sda);
    assign sda = slave_drv ? 1'b0 : 1'bz;
    assign sda_line = (sda === 1'b0) ? 1'b0 : 1'b1;

    i2c_master_seq #(.CLK_DIV(CLK_DIV), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .addr(addr), .rw(rw), .len(len),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .scl(scl), .sda(sda),
        .busy(busy), .done(done), .nack_err(nack_err), .dbg_state(dbg_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    // slave configuration, set by the stimulus before each transaction
    logic       cfg_ack = 1'b1;
    logic       cfg_rw = 1'b0;
    int         cfg_len = 0;
    logic [7:0] cfg_rd [0:1];

    // monitor state
    logic       scl_prev = 1'b1;
    logic       busy_prev = 1'b0;
    int         nrise = 0;
    int         base = 0;
    logic       bits [0:2047];
    int         tx_cnt = 0;
    int         rx_cnt = 0;
    int         busy_rise_cyc = 0;
    int         tx_cyc [0:15];
    logic [7:0] rx_byte [0:15];

    // Bit idx counts SCL rises since START: 0..7 address, 8 ack, then 9 per data byte.
    function automatic logic want(input int idx);
        int j, b;
        logic w;
        w = 1'b0;
        if (idx == 8) w = cfg_ack;
        else if (idx > 8) begin
            j = (idx - 9) / 9;
            b = (idx - 9) % 9;
            if (j < cfg_len) begin
                if (!cfg_rw) w = (b == 8) && cfg_ack;
                else if (b < 8) w = ~cfg_rd[j][7-b];
            end
        end
        return w;
    endfunction

    always @(negedge clk) begin
        scl_prev  <= scl;
        busy_prev <= busy;
        if (scl && !scl_prev) begin
            bits[nrise % 2048] <= sda_line;
            nrise <= nrise + 1;
        end
        if (!scl && scl_prev) slave_drv <= want(nrise - base);
        if (rst) slave_drv <= 1'b0;
        if (busy && !busy_prev) busy_rise_cyc <= cyc;
        if (tx_ready) begin
            tx_cyc[tx_cnt % 16] <= cyc;
            tx_cnt <= tx_cnt + 1;
        end
        if (rx_valid) begin
            rx_byte[rx_cnt % 16] <= rx_data;
            rx_cnt <= rx_cnt + 1;
        end
    end

    function automatic logic [7:0] bbyte(input int s);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[7-i] = bits[(s + i) % 2048];
        return r;
    endfunction

    // driver / checker tasks
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic do_start(input logic [6:0] a, input logic r, input logic [7:0] l);
        @(negedge clk);
        base  = nrise;
        addr  = a;
        rw    = r;
        len   = l;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int bound, output int dcyc, output logic found);
        found = 1'b0;
        dcyc  = 0;
        for (int i = 0; i < bound && !found; i++) begin
            @(negedge clk);
            if (done) begin
                found = 1'b1;
                dcyc  = cyc;
            end
        end
    endtask

    task automatic wait_tx(input int bound, output logic found);
        found = 1'b0;
        for (int i = 0; i < bound && !found; i++) begin
            @(negedge clk);
            if (tx_ready) found = 1'b1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   dc, t0, r0;
        logic f;

        // reset values
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_scl", scl, 1);
        check("rst_sda", sda_line, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_nack", nack_err, 0);
        check("rst_tx_ready", tx_ready, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_state", dbg_state, 0);
        @(negedge clk) rst = 1'b0;
        repeat (2) @(negedge clk);

        // write 0x12,0x34 to 0x50
        cfg_ack = 1'b1; cfg_rw = 1'b0; cfg_len = 2;
        tx_data = 8'h12; tx_valid = 1'b1;
        t0 = tx_cnt; r0 = rx_cnt;
        do_start(7'h50, 1'b0, 8'd2);
        check("wr_busy_rise", busy, 1);
        wait_tx(400, f);
        check("wr_tx1_seen", f, 1);
        @(posedge clk); #1 tx_data = 8'h34;
        wait_tx(400, f);
        check("wr_tx2_seen", f, 1);
        @(posedge clk); #1 tx_valid = 1'b0;
        wait_done(600, dc, f);
        check("wr_done_seen", f, 1);
        check("wr_busy_at_done", busy, 0);
        check("wr_time", dc - busy_rise_cyc, 464);
        check("wr_nack", nack_err, 0);
        check("wr_addr_byte", bbyte(base), 8'hA0);
        check("wr_byte0", bbyte(base + 9), 8'h12);
        check("wr_byte1", bbyte(base + 18), 8'h34);
        check("wr_tx_pulses", tx_cnt - t0, 2);
        check("wr_rx_pulses", rx_cnt - r0, 0);
        check("wr_rises", nrise - base, 28);
        check("wr_scl_idle", scl, 1);
        check("wr_sda_idle", sda_line, 1);

        // read 0xAB,0xCD from 0x51
        cfg_rw = 1'b1; cfg_len = 2; cfg_rd[0] = 8'hAB; cfg_rd[1] = 8'hCD;
        t0 = tx_cnt; r0 = rx_cnt;
        do_start(7'h51, 1'b1, 8'd2);
        wait_done(600, dc, f);
        check("rd_done_seen", f, 1);
        check("rd_time", dc - busy_rise_cyc, 464);
        check("rd_addr_byte", bbyte(base), 8'hA3);
        check("rd_addr_ack", bits[(base + 8) % 2048], 0);
        check("rd_rx_pulses", rx_cnt - r0, 2);
        check("rd_rx0", rx_byte[r0 % 16], 8'hAB);
        check("rd_rx1", rx_byte[(r0 + 1) % 16], 8'hCD);
        check("rd_rx_hold", rx_data, 8'hCD);
        check("rd_master_ack", bits[(base + 17) % 2048], 0);
        check("rd_master_nack", bits[(base + 26) % 2048], 1);
        check("rd_tx_pulses", tx_cnt - t0, 0);
        check("rd_nack", nack_err, 0);
        check("rd_rises", nrise - base, 28);

        // address NACK
        cfg_ack = 1'b0; cfg_rw = 1'b0; cfg_len = 1;
        tx_data = 8'h99; tx_valid = 1'b1;
        t0 = tx_cnt; r0 = rx_cnt;
        do_start(7'h22, 1'b0, 8'd1);
        wait_done(400, dc, f);
        check("an_done_seen", f, 1);
        check("an_nack", nack_err, 1);
        check("an_time", dc - busy_rise_cyc, 176);
        check("an_addr_byte", bbyte(base), 8'h44);
        check("an_ack_bit", bits[(base + 8) % 2048], 1);
        check("an_tx_pulses", tx_cnt - t0, 0);
        check("an_rx_pulses", rx_cnt - r0, 0);
        tx_valid = 1'b0;

        // probe, nack cleared, start while busy ignored
        cfg_ack = 1'b1; cfg_len = 0;
        do_start(7'h50, 1'b0, 8'd0);
        check("pr_nack_clr", nack_err, 0);
        repeat (40) @(posedge clk);
        #1 addr = 7'h7F; rw = 1'b1; len = 8'd5; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(400, dc, f);
        check("pr_done_seen", f, 1);
        check("pr_time", dc - busy_rise_cyc, 176);
        check("pr_addr_byte", bbyte(base), 8'hA0);
        check("pr_rises", nrise - base, 10);
        repeat (5) @(negedge clk);
        check("pr_no_restart", busy, 0);

        // tx_valid stall of 50 cycles before byte 2
        cfg_len = 2; cfg_rw = 1'b0;
        tx_data = 8'h5A; tx_valid = 1'b1;
        t0 = tx_cnt;
        do_start(7'h50, 1'b0, 8'd2);
        wait_tx(400, f);
        check("st_tx1_seen", f, 1);
        @(posedge clk); #1 tx_valid = 1'b0; tx_data = 8'hC3;
        repeat (170) @(posedge clk);
        #1 check("st_scl_low", scl, 0);
        check("st_no_ready", tx_ready, 0);
        repeat (23) @(posedge clk);
        #1 tx_valid = 1'b1;
        wait_tx(10, f);
        check("st_tx2_seen", f, 1);
        @(posedge clk); #1 tx_valid = 1'b0;
        wait_done(700, dc, f);
        check("st_done_seen", f, 1);
        check("st_time", dc - busy_rise_cyc, 514);
        check("st_tx_gap", tx_cyc[(t0 + 1) % 16] - tx_cyc[t0 % 16], 194);
        check("st_addr_byte", bbyte(base), 8'hA0);
        check("st_byte0", bbyte(base + 9), 8'h5A);
        check("st_byte1", bbyte(base + 18), 8'hC3);
        check("st_nack", nack_err, 0);

        // reset mid-byte (address bit 3, SCL low, SDA driven low)
        cfg_len = 1; tx_data = 8'h77; tx_valid = 1'b1;
        do_start(7'h50, 1'b0, 8'd1);
        repeat (65) @(posedge clk);
        #1 check("mr_pre_scl", scl, 0);
        check("mr_pre_sda", sda_line, 0);
        rst = 1'b1;
        #1 check("mr_scl", scl, 1);
        check("mr_sda", sda_line, 1);
        check("mr_busy", busy, 0);
        check("mr_done", done, 0);
        check("mr_state", dbg_state, 0);
        @(negedge clk) rst = 1'b0;
        repeat (3) @(negedge clk);
        t0 = tx_cnt;
        do_start(7'h50, 1'b0, 8'd1);
        wait_tx(400, f);
        check("mr_tx_seen", f, 1);
        @(posedge clk); #1 tx_valid = 1'b0;
        wait_done(600, dc, f);
        check("mr_done_seen", f, 1);
        check("mr_time", dc - busy_rise_cyc, 320);
        check("mr_addr_byte", bbyte(base), 8'hA0);
        check("mr_byte0", bbyte(base + 9), 8'h77);
        check("mr_tx_pulses", tx_cnt - t0, 1);
        check("mr_nack", nack_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
